// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// fields, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC_R = 4'd7,
        ALUWB  = 4'd8,
        EXEC_I = 4'd9,
        IWB    = 4'd10,
        BRANCH = 4'd11,
        JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SIGNEXT = 2'b10;
    localparam logic [1:0] SRCB_BRANCH  = 2'b11;

    localparam logic [1:0] PC_ALU_RESULT = 2'b00;
    localparam logic [1:0] PC_ALU_OUT    = 2'b01;
    localparam logic [1:0] PC_JUMP       = 2'b10;

    function automatic logic is_done_state(input state_t s);
        return (s == MEMWB) || (s == MEMWR) || (s == ALUWB) ||
               (s == IWB)   || (s == BRANCH) || (s == JUMP);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU operation select for each controller state, plus detection of R-type
// funct codes the datapath does not implement.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  state_t                state,
    input  logic [5:0]            Opcode,
    input  logic [5:0]            Funct,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  funct_illegal
);

    logic [3:0] funct_op;
    logic [3:0] alu_op;

    // funct_illegal must not depend on state: the FSM uses it to pick the next state.
    always_comb begin
        funct_op      = ALU_AND;
        funct_illegal = 1'b0;
        case (Funct)
            FN_ADD:  funct_op = ALU_ADD;
            FN_SUB:  funct_op = ALU_SUB;
            FN_AND:  funct_op = ALU_AND;
            FN_OR:   funct_op = ALU_OR;
            FN_SLT:  funct_op = ALU_SLT;
            FN_SLL:  funct_op = ALU_SLL;
            FN_SRL:  funct_op = ALU_SRL;
            default: funct_illegal = (Opcode == OP_RTYPE);
        endcase
    end

    always_comb begin
        alu_op = ALU_AND;
        case (state)
            FETCH, DECODE, MEMADR: alu_op = ALU_ADD;
            EXEC_R:                alu_op = funct_op;
            EXEC_I: begin
                case (Opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            BRANCH:                alu_op = ALU_SUB;
            default:               alu_op = ALU_AND;
        endcase
    end

    assign ALUControl = ALU_CTRL_W'(alu_op);

endmodule

// File: rtl/mips_multicycle_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/writeback and
// drives every datapath strobe from a registered copy of the next state.
module mips_multicycle_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int ENABLE_BNE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [5:0]            Opcode,
    input  logic [5:0]            Funct,
    input  logic                  Zero,
    output logic                  IorD,
    output logic                  Mem_select,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  DataWrite,
    output logic                  RDx_FF_en,
    output logic                  ALUresult_en,
    output logic                  RegDst,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [1:0]            PCSrc,
    output logic                  PCWrite,
    output logic                  Branch,
    output logic                  PC_En,
    output logic                  instr_done,
    output logic                  illegal_op,
    output logic [3:0]            state
);

    state_t                state_q;
    state_t                state_d;
    logic                  is_load_q;
    logic                  is_bne_q;
    logic                  decode_illegal;
    logic                  funct_illegal;
    logic [ALU_CTRL_W-1:0] alu_ctrl_d;

    // Fed with the next state so ALUControl can be registered alongside the other strobes.
    mips_alu_decoder #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_alu_decoder (
        .state        (state_d),
        .Opcode       (Opcode),
        .Funct        (Funct),
        .ALUControl   (alu_ctrl_d),
        .funct_illegal(funct_illegal)
    );

    always_comb begin
        state_d        = IDLE;
        decode_illegal = 1'b0;
        case (state_q)
            IDLE:   state_d = run ? FETCH : IDLE;
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:             state_d = MEMADR;
                    OP_RTYPE: begin
                        if (funct_illegal) decode_illegal = 1'b1;
                        else               state_d = EXEC_R;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = EXEC_I;
                    OP_BEQ:                   state_d = BRANCH;
                    OP_BNE: begin
                        if (ENABLE_BNE != 0) state_d = BRANCH;
                        else                 decode_illegal = 1'b1;
                    end
                    OP_J:                     state_d = JUMP;
                    default:                  decode_illegal = 1'b1;
                endcase
                if (decode_illegal) state_d = run ? FETCH : IDLE;
            end
            MEMADR: state_d = is_load_q ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXEC_R: state_d = ALUWB;
            EXEC_I: state_d = IWB;
            MEMWB, MEMWR, ALUWB, IWB, BRANCH, JUMP: state_d = run ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            is_load_q    <= 1'b0;
            is_bne_q     <= 1'b0;
            IorD         <= 1'b0;
            Mem_select   <= 1'b0;
            MemWrite     <= 1'b0;
            IRWrite      <= 1'b0;
            DataWrite    <= 1'b0;
            RDx_FF_en    <= 1'b0;
            ALUresult_en <= 1'b0;
            RegDst       <= 1'b0;
            MemtoReg     <= 1'b0;
            RegWrite     <= 1'b0;
            ALUSrcA      <= 1'b0;
            ALUSrcB      <= SRCB_REG;
            ALUControl   <= '0;
            PCSrc        <= PC_ALU_RESULT;
            PCWrite      <= 1'b0;
            Branch       <= 1'b0;
            instr_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            IorD         <= 1'b0;
            Mem_select   <= 1'b0;
            MemWrite     <= 1'b0;
            IRWrite      <= 1'b0;
            DataWrite    <= 1'b0;
            RDx_FF_en    <= 1'b0;
            ALUresult_en <= 1'b0;
            RegDst       <= 1'b0;
            MemtoReg     <= 1'b0;
            RegWrite     <= 1'b0;
            ALUSrcA      <= 1'b0;
            ALUSrcB      <= SRCB_REG;
            ALUControl   <= alu_ctrl_d;
            PCSrc        <= PC_ALU_RESULT;
            PCWrite      <= 1'b0;
            Branch       <= 1'b0;
            instr_done   <= is_done_state(state_d);
            if (state_q == DECODE) begin
                is_load_q <= (Opcode == OP_LW);
                is_bne_q  <= (Opcode == OP_BNE);
            end
            case (state_d)
                FETCH: begin
                    IRWrite <= 1'b1;
                    ALUSrcB <= SRCB_FOUR;
                    PCWrite <= 1'b1;
                end
                DECODE: begin
                    RDx_FF_en    <= 1'b1;
                    ALUSrcB      <= SRCB_BRANCH;
                    ALUresult_en <= 1'b1;
                end
                MEMADR, EXEC_I: begin
                    ALUSrcA      <= 1'b1;
                    ALUSrcB      <= SRCB_SIGNEXT;
                    ALUresult_en <= 1'b1;
                end
                MEMRD: begin
                    IorD       <= 1'b1;
                    Mem_select <= 1'b1;
                    DataWrite  <= 1'b1;
                end
                MEMWB: begin
                    MemtoReg <= 1'b1;
                    RegWrite <= 1'b1;
                end
                MEMWR: begin
                    IorD       <= 1'b1;
                    Mem_select <= 1'b1;
                    MemWrite   <= 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA      <= 1'b1;
                    ALUresult_en <= 1'b1;
                end
                ALUWB: begin
                    RegDst   <= 1'b1;
                    RegWrite <= 1'b1;
                end
                IWB:    RegWrite <= 1'b1;
                BRANCH: begin
                    ALUSrcA <= 1'b1;
                    Branch  <= 1'b1;
                    PCSrc   <= PC_ALU_OUT;
                end
                JUMP: begin
                    PCSrc   <= PC_JUMP;
                    PCWrite <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Zero arrives from the ALU in the BRANCH cycle itself, so this stays combinational.
    assign PC_En      = PCWrite | (Branch & (Zero ^ is_bne_q));
    assign illegal_op = decode_illegal;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_fsm.sv
// Self-checking bench for mips_multicycle_fsm: instruction-path reference model
// compared every cycle, plus directed instruction sequences with literal expectations.
module tb_mips_multicycle_fsm;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4;
    localparam int S_MEMWB = 5, S_MEMWR = 6, S_EXEC_R = 7, S_ALUWB = 8, S_EXEC_I = 9;
    localparam int S_IWB = 10, S_BRANCH = 11, S_JUMP = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       Zero = 1'b0;
    logic [5:0] Opcode = 6'h00;
    logic [5:0] Funct = 6'h20;

    logic       IorD, Mem_select, MemWrite, IRWrite, DataWrite, RDx_FF_en, ALUresult_en;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, Branch, PC_En, instr_done, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUControl, state;

    mips_multicycle_fsm #(
        .ALU_CTRL_W(4),
        .ENABLE_BNE(1)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .Mem_select(Mem_select), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .DataWrite(DataWrite), .RDx_FF_en(RDx_FF_en), .ALUresult_en(ALUresult_en),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .Branch(Branch), .PC_En(PC_En), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord, mem_sel, memwrite, irwrite, datawrite, rdx, aluout_en;
        logic       regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluctl;
        logic [1:0] pcsrc;
        logic       pcwrite, branch, pc_en, done, illegal;
        logic [3:0] st;
    } ctl_t;

    ctl_t dut_c;
    assign dut_c = {IorD, Mem_select, MemWrite, IRWrite, DataWrite, RDx_FF_en, ALUresult_en,
                    RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc,
                    PCWrite, Branch, PC_En, instr_done, illegal_op, state};

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // States an instruction visits after DECODE; -1 past the end (or for an illegal instruction).
    function automatic int path_step(input logic [5:0] op, input logic [5:0] fn, input int idx);
        int p[3];
        p = '{-1, -1, -1};
        case (op)
            6'h23: p = '{S_MEMADR, S_MEMRD, S_MEMWB};
            6'h2B: p = '{S_MEMADR, S_MEMWR, -1};
            6'h00: if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02})
                       p = '{S_EXEC_R, S_ALUWB, -1};
            6'h08, 6'h0C, 6'h0D: p = '{S_EXEC_I, S_IWB, -1};
            6'h04, 6'h05: p = '{S_BRANCH, -1, -1};
            6'h02: p = '{S_JUMP, -1, -1};
            default: ;
        endcase
        if (idx < 0 || idx > 2) return -1;
        return p[idx];
    endfunction

    function automatic ctl_t exp_out(input int s, input logic [5:0] op, input logic [5:0] fn,
                                     input logic z, input logic bne);
        ctl_t c;
        c = '0;
        c.st = 4'(s);
        case (s)
            S_FETCH:  begin c.irwrite = 1; c.alusrcb = 2'b01; c.aluctl = 4'b0010; c.pcwrite = 1; end
            S_DECODE: begin
                c.rdx = 1; c.alusrcb = 2'b11; c.aluctl = 4'b0010; c.aluout_en = 1;
                c.illegal = (path_step(op, fn, 0) < 0);
            end
            S_MEMADR: begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluctl = 4'b0010; c.aluout_en = 1; end
            S_MEMRD:  begin c.iord = 1; c.mem_sel = 1; c.datawrite = 1; end
            S_MEMWB:  begin c.memtoreg = 1; c.regwrite = 1; c.done = 1; end
            S_MEMWR:  begin c.iord = 1; c.mem_sel = 1; c.memwrite = 1; c.done = 1; end
            S_EXEC_R: begin
                c.alusrca = 1; c.aluout_en = 1;
                case (fn)
                    6'h20: c.aluctl = 4'b0010;
                    6'h22: c.aluctl = 4'b0110;
                    6'h24: c.aluctl = 4'b0000;
                    6'h25: c.aluctl = 4'b0001;
                    6'h2A: c.aluctl = 4'b0111;
                    6'h00: c.aluctl = 4'b1000;
                    6'h02: c.aluctl = 4'b1001;
                    default: ;
                endcase
            end
            S_ALUWB:  begin c.regdst = 1; c.regwrite = 1; c.done = 1; end
            S_EXEC_I: begin
                c.alusrca = 1; c.alusrcb = 2'b10; c.aluout_en = 1;
                c.aluctl = (op == 6'h0C) ? 4'b0000 : (op == 6'h0D) ? 4'b0001 : 4'b0010;
            end
            S_IWB:    begin c.regwrite = 1; c.done = 1; end
            S_BRANCH: begin c.alusrca = 1; c.aluctl = 4'b0110; c.branch = 1; c.pcsrc = 2'b01; c.done = 1; end
            S_JUMP:   begin c.pcsrc = 2'b10; c.pcwrite = 1; c.done = 1; end
            default: ;
        endcase
        c.pc_en = c.pcwrite | (c.branch & (z ^ bne));
        return c;
    endfunction

    int         m_state = S_IDLE;
    int         m_idx = 0;
    logic [5:0] m_op = 6'h00;
    logic [5:0] m_fn = 6'h00;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state <= S_IDLE;
            m_idx   <= 0;
            m_op    <= 6'h00;
        end else begin
            case (m_state)
                S_IDLE:   m_state <= run ? S_FETCH : S_IDLE;
                S_FETCH:  m_state <= S_DECODE;
                S_DECODE: begin
                    m_op    <= Opcode;
                    m_fn    <= Funct;
                    m_idx   <= 0;
                    m_state <= (path_step(Opcode, Funct, 0) < 0) ? (run ? S_FETCH : S_IDLE)
                                                                 : path_step(Opcode, Funct, 0);
                end
                default: begin
                    m_idx   <= m_idx + 1;
                    m_state <= (path_step(m_op, m_fn, m_idx + 1) < 0) ? (run ? S_FETCH : S_IDLE)
                                                                      : path_step(m_op, m_fn, m_idx + 1);
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            ctl_t e;
            e = exp_out(m_state, Opcode, Funct, Zero, (m_op == 6'h05));
            n_checks++;
            if (dut_c !== e) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got %h required %h", $time, dut_c, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    ctl_t obs[8];
    int   done_cnt;

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int seq[5], input int n, input int drop_at,
                             input int exp_after);
        int k;
        Opcode = op;
        Funct  = fn;
        Zero   = z;
        k = 0;
        while (state != 4'(S_FETCH) && k < 6) begin
            step(1);
            k++;
        end
        check({name, " reach FETCH"}, 32'(state), S_FETCH);
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            check({name, " state seq"}, 32'(state), seq[i]);
            obs[i] = dut_c;
            if (instr_done) done_cnt++;
            if (i == drop_at) run = 1'b0;
            step(1);
        end
        check({name, " state after"}, 32'(state), exp_after);
    endtask

    initial begin
        #1 reset = 1'b0;
        chk_on = 1'b1;
        step(2);
        check("reset state", 32'(state), S_IDLE);
        check("reset outputs", 32'(dut_c), 32'h0);

        // Reset in the middle of a load.
        reset  = 1'b1;
        run    = 1'b1;
        Opcode = 6'h23;
        begin
            int k;
            k = 0;
            while (state != 4'(S_MEMRD) && k < 10) begin
                step(1);
                k++;
            end
        end
        check("reach MEMRD", 32'(state), S_MEMRD);
        reset = 1'b0;
        #1;
        check("mid-MEMRD reset state", 32'(state), S_IDLE);
        check("mid-MEMRD reset outputs", 32'(dut_c), 32'h0);
        run = 1'b0;
        step(1);
        reset = 1'b1;
        step(3);
        check("idle with run=0", 32'(state), S_IDLE);

        run = 1'b1;
        run_instr("lw", 6'h23, 6'h00, 1'b0, '{1, 2, 3, 4, 5}, 5, -1, S_FETCH);
        check("lw MEMWB RegWrite", 32'(obs[4].regwrite), 1);
        check("lw MEMWB MemtoReg", 32'(obs[4].memtoreg), 1);
        check("lw instr_done pulses", done_cnt, 1);

        run_instr("sw", 6'h2B, 6'h00, 1'b0, '{1, 2, 3, 6, 0}, 4, -1, S_FETCH);
        check("sw MemWrite", 32'(obs[3].memwrite), 1);

        run_instr("sub", 6'h00, 6'h22, 1'b0, '{1, 2, 7, 8, 0}, 4, -1, S_FETCH);
        check("sub ALUControl", 32'(obs[2].aluctl), 32'h6);
        check("sub RegDst", 32'(obs[3].regdst), 1);

        run_instr("sll", 6'h00, 6'h00, 1'b0, '{1, 2, 7, 8, 0}, 4, -1, S_FETCH);
        check("sll ALUControl", 32'(obs[2].aluctl), 32'h8);

        run_instr("andi", 6'h0C, 6'h00, 1'b0, '{1, 2, 9, 10, 0}, 4, -1, S_FETCH);
        check("andi ALUControl", 32'(obs[2].aluctl), 32'h0);
        run_instr("ori", 6'h0D, 6'h00, 1'b0, '{1, 2, 9, 10, 0}, 4, -1, S_FETCH);
        check("ori ALUControl", 32'(obs[2].aluctl), 32'h1);

        run_instr("beq taken", 6'h04, 6'h00, 1'b1, '{1, 2, 11, 0, 0}, 3, -1, S_FETCH);
        check("beq Z=1 PC_En", 32'(obs[2].pc_en), 1);
        check("beq PCSrc", 32'(obs[2].pcsrc), 1);
        run_instr("beq not taken", 6'h04, 6'h00, 1'b0, '{1, 2, 11, 0, 0}, 3, -1, S_FETCH);
        check("beq Z=0 PC_En", 32'(obs[2].pc_en), 0);
        run_instr("bne Z=1", 6'h05, 6'h00, 1'b1, '{1, 2, 11, 0, 0}, 3, -1, S_FETCH);
        check("bne Z=1 PC_En", 32'(obs[2].pc_en), 0);
        run_instr("bne Z=0", 6'h05, 6'h00, 1'b0, '{1, 2, 11, 0, 0}, 3, -1, S_FETCH);
        check("bne Z=0 PC_En", 32'(obs[2].pc_en), 1);
        check("bne PCSrc", 32'(obs[2].pcsrc), 1);

        run_instr("j", 6'h02, 6'h00, 1'b0, '{1, 2, 12, 0, 0}, 3, -1, S_FETCH);
        check("j PCSrc", 32'(obs[2].pcsrc), 2);
        check("j PC_En", 32'(obs[2].pc_en), 1);

        run_instr("bad opcode", 6'h3F, 6'h00, 1'b0, '{1, 2, 0, 0, 0}, 2, -1, S_FETCH);
        check("bad opcode illegal_op", 32'(obs[1].illegal), 1);
        check("bad opcode no FETCH flag", 32'(obs[0].illegal), 0);
        check("bad opcode instr_done", done_cnt, 0);
        run_instr("bad funct", 6'h00, 6'h3F, 1'b0, '{1, 2, 0, 0, 0}, 2, -1, S_FETCH);
        check("bad funct illegal_op", 32'(obs[1].illegal), 1);

        // Drop run during EXEC_I: IWB completes, then the FSM parks.
        run_instr("addi run drop", 6'h08, 6'h00, 1'b0, '{1, 2, 9, 10, 0}, 4, 2, S_IDLE);
        step(2);
        check("parked in IDLE", 32'(state), S_IDLE);
        run = 1'b1;
        step(1);
        check("restart FETCH", 32'(state), S_FETCH);
        run = 1'b0;
        step(8);
        check("final IDLE", 32'(state), S_IDLE);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
